// File: rtl/pipe_share_sched_if.sv
// Requester/response bus of the shared-datapath scheduler.
// Master is the requester/consumer side; slave is the scheduler.
interface pipe_share_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic [ID_W-1:0]           resp_id;

    modport master (
        output req_valid, req_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/pipe_share_sched.sv
// Round-robin scheduler sharing one fixed-latency datapath among requesters,
// with a tag pipe tracking in-flight words and a credit-limited result FIFO.
module pipe_share_sched #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [DATA_W-1:0] dp_in_data,
    input  logic [DATA_W-1:0] dp_out_data,
    output logic              busy,
    pipe_share_sched_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(LATENCY + FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [ID_W-1:0]               last_grant_q;
    logic [LATENCY-1:0]            tag_vld_q;
    logic [LATENCY-1:0][ID_W-1:0]  tag_id_q;
    logic [CNT_W-1:0]              inflight_q, inflight_d;
    logic [CNT_W-1:0]              fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]              rd_ptr_q, wr_ptr_q;
    logic [DATA_W-1:0]             mem_data_q [FIFO_DEPTH];
    logic [ID_W-1:0]               mem_id_q   [FIFO_DEPTH];

    logic                can_issue_c, found_c, xfer_c, push_c, pop_c, resp_valid_c;
    logic [ID_W-1:0]     gnt_id_c;
    logic [DATA_W-1:0]   sel_data_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits are taken from registered counts only, so a pop never frees
    // an issue slot in the same cycle.
    assign can_issue_c = rst_n & enable &
                         ((inflight_q + fifo_cnt_q) < CNT_W'(FIFO_DEPTH));

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        found_c  = 1'b0;
        gnt_id_c = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!found_c && bus.req_valid[ID_W'((32'(last_grant_q) + k) % NUM_REQ)]) begin
                found_c  = 1'b1;
                gnt_id_c = ID_W'((32'(last_grant_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        sel_data_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_id_c == ID_W'(i)) sel_data_c = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    assign xfer_c        = can_issue_c & found_c;
    assign bus.req_ready = xfer_c ? (NUM_REQ'(1) << gnt_id_c) : '0;
    assign dp_in_data    = xfer_c ? sel_data_c : '0;

    assign push_c       = tag_vld_q[LATENCY-1];
    assign resp_valid_c = (fifo_cnt_q != '0);
    assign pop_c        = resp_valid_c & bus.resp_ready;

    assign inflight_d = inflight_q + CNT_W'(xfer_c) - CNT_W'(push_c);
    assign fifo_cnt_d = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);

    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_data  = resp_valid_c ? mem_data_q[rd_ptr_q] : '0;
    assign bus.resp_id    = resp_valid_c ? mem_id_q[rd_ptr_q]   : '0;
    assign busy           = (inflight_q != '0) | (fifo_cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            inflight_q   <= '0;
            fifo_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            if (xfer_c) last_grant_q <= gnt_id_c;
            tag_vld_q  <= {tag_vld_q[LATENCY-2:0], xfer_c};
            tag_id_q   <= {tag_id_q[LATENCY-2:0], gnt_id_c};
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    // Storage needs no reset: entries are only visible behind fifo_cnt_q.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data_q[wr_ptr_q] <= dp_out_data;
            mem_id_q[wr_ptr_q]   <= tag_id_q[LATENCY-1];
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_c && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
endmodule

// File: tb/tb_pipe_share_sched.sv
// Directed bench for pipe_share_sched with a 4-register datapath model.
module tb_pipe_share_sched;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned LATENCY = 4;
    localparam int unsigned ID_W    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [DATA_W-1:0] dp_in_data;
    logic [DATA_W-1:0] dp_out_data;
    logic              busy;
    logic [DATA_W-1:0] dp_s [LATENCY];

    int n_pass  = 0;
    int n_total = 0;
    int got;
    int n;
    int seen;
    logic [DATA_W-1:0] exp_q [$];
    logic [ID_W-1:0]   id_q  [$];

    pipe_share_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    pipe_share_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LATENCY(LATENCY),
                       .FIFO_DEPTH(4), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .dp_in_data(dp_in_data), .dp_out_data(dp_out_data),
        .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    // Non-reset datapath: plain delay line.
    always @(posedge clk) begin
        dp_s[0] <= dp_in_data;
        for (int i = 1; i < int'(LATENCY); i++) dp_s[i] <= dp_s[i-1];
    end
    assign dp_out_data = dp_s[LATENCY-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input int i, input logic [DATA_W-1:0] d);
        bus.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        enable         = 1'b0;
        exp_q.delete();
        id_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_resp(input string tag);
        if (bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_unexpected"}, 32'(bus.resp_valid), 32'(0));
            end else begin
                chk({tag, "_data"}, 32'(bus.resp_data), 32'(exp_q[0]));
                chk({tag, "_id"}, 32'(bus.resp_id), 32'(id_q[0]));
                if (bus.resp_ready) begin
                    void'(exp_q.pop_front());
                    void'(id_q.pop_front());
                    got++;
                end
            end
        end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.resp_ready = 1'b0;
        #13;
        bus.req_valid = 4'hF;
        enable        = 1'b1;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_dp_in", 32'(dp_in_data), 32'(0));
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
        chk("rst_resp_data", 32'(bus.resp_data), 32'(0));
        chk("rst_resp_id", 32'(bus.resp_id), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        do_reset();

        // Single request from requester 2.
        enable = 1'b1;
        bus.resp_ready = 1'b1;
        set_data(2, 16'hA5A5);
        bus.req_valid = 4'b0100;
        #1;
        chk("t1_grant", 32'(bus.req_ready), 32'h4);
        chk("t1_dp_in", 32'(dp_in_data), 32'hA5A5);
        tick();
        bus.req_valid = '0;
        #1;
        chk("t1_busy_inflight", 32'(busy), 32'(1));
        tick(); tick(); tick();
        chk("t1_not_yet", 32'(bus.resp_valid), 32'(0));
        tick();
        chk("t1_resp_valid", 32'(bus.resp_valid), 32'(1));
        chk("t1_resp_data", 32'(bus.resp_data), 32'hA5A5);
        chk("t1_resp_id", 32'(bus.resp_id), 32'(2));
        tick();
        chk("t1_popped", 32'(bus.resp_valid), 32'(0));
        chk("t1_busy_low", 32'(busy), 32'(0));

        // Round robin with all requesters valid.
        do_reset();
        enable = 1'b1;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_data(i, 16'h2000 + 16'(i));
        bus.req_valid = 4'hF;
        n = 0;
        got = 0;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (c == 4) chk("t2_credit_block", 32'(bus.req_ready), 32'(0));
            if (bus.req_ready != '0) begin
                chk("t2_grant", 32'(bus.req_ready), 32'(1) << (n % 4));
                exp_q.push_back(16'h2000 + 16'(n % 4));
                id_q.push_back(ID_W'(n % 4));
                n++;
            end
            check_resp("t2_resp");
            tick();
        end
        bus.req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_resp("t2_drain");
            tick();
        end
        chk("t2_enough_grants", 32'(n >= 12), 32'(1));
        chk("t2_all_returned", 32'(got), 32'(n));
        chk("t2_busy_low", 32'(busy), 32'(0));

        // Backpressure with requester 1 streaming.
        do_reset();
        enable = 1'b1;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            set_data(1, 16'hB000 + 16'(n));
            bus.req_valid = 4'b0010;
            #1;
            if (bus.req_ready[1]) begin
                exp_q.push_back(16'hB000 + 16'(n));
                id_q.push_back(ID_W'(1));
                n++;
            end
            tick();
        end
        chk("t3_accepted", 32'(n), 32'(4));
        set_data(1, 16'hB000 + 16'(n));
        #1;
        chk("t3_stalled", 32'(bus.req_ready), 32'(0));
        chk("t3_head_data", 32'(bus.resp_data), 32'hB000);
        chk("t3_head_id", 32'(bus.resp_id), 32'(1));
        bus.resp_ready = 1'b1;
        #1;
        chk("t3_no_same_cycle_credit", 32'(bus.req_ready), 32'(0));
        tick();
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
        bus.resp_ready = 1'b0;
        #1;
        chk("t3_one_credit", 32'(bus.req_ready), 32'h2);
        exp_q.push_back(16'hB000 + 16'(n));
        id_q.push_back(ID_W'(1));
        tick();
        set_data(1, 16'hB0FF);
        #1;
        chk("t3_credit_used", 32'(bus.req_ready), 32'(0));
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            check_resp("t3_drain");
            tick();
        end
        chk("t3_drained", 32'(got), 32'(4));
        chk("t3_busy_low", 32'(busy), 32'(0));

        // Enable drops after three issues; in-flight words still drain.
        do_reset();
        enable = 1'b1;
        bus.resp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 3; k++) begin
            set_data(3, 16'hC000 + 16'(k));
            bus.req_valid = 4'b1000;
            #1;
            chk("t4_grant", 32'(bus.req_ready), 32'h8);
            exp_q.push_back(16'hC000 + 16'(k));
            id_q.push_back(ID_W'(3));
            tick();
        end
        enable = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("t4_no_grant", 32'(bus.req_ready), 32'(0));
            check_resp("t4_resp");
            tick();
        end
        chk("t4_delivered", 32'(got), 32'(3));
        chk("t4_busy_low", 32'(busy), 32'(0));

        // Reset with two words in the tag pipe and one in the FIFO.
        do_reset();
        enable = 1'b1;
        set_data(0, 16'hE000);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        bus.req_valid = 4'b0001;
        set_data(0, 16'hE001);
        tick();
        set_data(0, 16'hE002);
        tick();
        #1;
        chk("t5_fifo_loaded", 32'(bus.resp_valid), 32'(1));
        chk("t5_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req_ready", 32'(bus.req_ready), 32'(0));
        chk("t5_rst_dp_in", 32'(dp_in_data), 32'(0));
        chk("t5_rst_resp_valid", 32'(bus.resp_valid), 32'(0));
        chk("t5_rst_resp_data", 32'(bus.resp_data), 32'(0));
        chk("t5_rst_resp_id", 32'(bus.resp_id), 32'(0));
        chk("t5_rst_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.resp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.resp_valid) seen++;
            tick();
        end
        chk("t5_no_stale_resp", 32'(seen), 32'(0));
        bus.req_valid = 4'hF;
        #1;
        chk("t5_first_grant", 32'(bus.req_ready), 32'h1);
        bus.req_valid = '0;

        // FIFO at three entries sees push and pop on the same edge.
        do_reset();
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_data(2, 16'hD000 + 16'(k));
            bus.req_valid = 4'b0100;
            #1;
            chk("t6_grant", 32'(bus.req_ready), 32'h4);
            exp_q.push_back(16'hD000 + 16'(k));
            id_q.push_back(ID_W'(2));
            tick();
        end
        bus.req_valid = '0;
        tick();
        tick();
        tick();
        #1;
        chk("t6_head_before", 32'(bus.resp_data), 32'hD000);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
        #1;
        chk("t6_head_after", 32'(bus.resp_data), 32'hD001);
        chk("t6_busy", 32'(busy), 32'(1));
        bus.resp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            check_resp("t6_drain");
            tick();
        end
        chk("t6_count_kept", 32'(got), 32'(3));
        chk("t6_busy_low", 32'(busy), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
